// File: rtl/ifetch_rd_responder_pkg.sv
// Shared types and constants for the fetch read responder: response codes,
// FSM encoding, channel widths and the address window test.
package ifetch_rd_responder_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_READ = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Compared in 33 bits so a window ending at 2^32 cannot wrap.
    function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base,
                                       input logic [ADDR_W-1:0] size);
        logic [ADDR_W:0] a;
        logic [ADDR_W:0] lo;
        logic [ADDR_W:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = {1'b0, base} + {1'b0, size};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/ifetch_rd_responder_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded with 8'hA5; used only when
// IFETCH_RD_RAND_DELAY_EN adds random wait cycles.
module lfsr8
    import ifetch_rd_responder_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       en_i,
    output logic [7:0] state_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic       fb;

    assign fb      = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign lfsr_d  = en_i ? {lfsr_q[6:0], fb} : lfsr_q;
    assign state_o = lfsr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/ifetch_rd_responder.sv
// Single-outstanding AR/R read responder in front of the instruction SRAM.
// Define IFETCH_RD_RAND_DELAY_EN to add 0..7 LFSR-driven wait cycles per read.
module ifetch_rd_responder
    import ifetch_rd_responder_pkg::*;
#(
    parameter int unsigned       LATENCY  = 2,
    parameter logic [ADDR_W-1:0] MEM_BASE = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] MEM_SIZE = 32'h0800_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ar_valid,
    output logic              ar_ready,
    input  logic [ADDR_W-1:0] ar_bits_addr,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [DATA_W-1:0] r_bits_data,
    output logic [1:0]        r_bits_resp,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        resp_q, resp_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]  lat_load;

`ifdef IFETCH_RD_RAND_DELAY_EN
    logic [7:0] lfsr_state;
    logic       unused_lfsr_hi;

    lfsr8 u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .en_i    (1'b1),
        .state_o (lfsr_state)
    );

    assign unused_lfsr_hi = ^lfsr_state[7:3];
    assign lat_load       = CNT_W'(LATENCY) + CNT_W'(lfsr_state[2:0]);
`else
    assign lat_load = CNT_W'(LATENCY);
`endif

    assign mem_addr = mem_addr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            resp_q     <= RESP_OKAY;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            resp_q     <= resp_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        resp_d      = resp_q;
        mem_addr_d  = mem_addr_q;
        ar_ready    = 1'b0;
        r_valid     = 1'b0;
        mem_en      = 1'b0;
        r_bits_data = data_q;
        r_bits_resp = resp_q;

        case (state_q)
            ST_IDLE: begin
                ar_ready = 1'b1;
                if (ar_valid) begin
                    // Misalignment outranks the window check.
                    if (ar_bits_addr[1:0] != 2'b00) begin
                        resp_d  = RESP_SLVERR;
                        data_d  = '0;
                        state_d = ST_RESP;
                    end else if (!in_window(ar_bits_addr, MEM_BASE, MEM_SIZE)) begin
                        resp_d  = RESP_DECERR;
                        data_d  = '0;
                        state_d = ST_RESP;
                    end else begin
                        mem_addr_d = ar_bits_addr - MEM_BASE;
                        cnt_d      = lat_load;
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    mem_en  = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                // SRAM data is forwarded straight out and also held for stalls.
                r_valid     = 1'b1;
                r_bits_data = mem_rdata;
                r_bits_resp = RESP_OKAY;
                data_d      = mem_rdata;
                resp_d      = RESP_OKAY;
                state_d     = r_ready ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                r_valid = 1'b1;
                if (r_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
